div7_engine_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one largest-divisible-by-7 search engine among NREQ requesters.
- The engine exposes:
  - a Start/Ack handshake;
  - one-hot status (Qi = initial, Qdf = done/found, Qdnf = done/not-found);
  - an 8-bit Max result.
- Per requester: grants the engine, drives Start, waits for a done state, captures the result, issues Ack, and returns a one-cycle Done pulse with the result.
- Gnt is one-hot; it is also used externally to steer the granted requester's 16-entry array into the engine.

---
 rtl/div7_engine_arbiter.sv | 111 +++++++++++
 tb/tb_div7_engine_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div7_engine_arbiter.sv
// div7_engine_arbiter: round-robin sharing of one div-by-7 search engine among NREQ requesters; DIV7_ARB_TIMEOUT_EN adds a WAIT watchdog and Timeout port
module div7_engine_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [NREQ-1:0] Req,
    output logic [NREQ-1:0] Gnt,
    output logic [NREQ-1:0] Done,
    output logic            Found,
    output logic [7:0]      Result,
    output logic            Eng_Start,
    output logic            Eng_Ack,
    input  logic            Eng_Qi,
    input  logic            Eng_Qdf,
    input  logic            Eng_Qdnf,
    input  logic [7:0]      Eng_Max,
`ifdef DIV7_ARB_TIMEOUT_EN
    output logic            Timeout,
`endif
    output logic            Busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, gidx, pick_idx, j;
    logic [NREQ-1:0] pick;
    logic hit, eng_done, wait_exit;
    int idx;
    assign eng_done = Eng_Qdf | Eng_Qdnf;
`ifdef DIV7_ARB_TIMEOUT_EN
    logic [7:0] wd;
    assign wait_exit = eng_done || (wd == 8'(TIMEOUT - 1));
`else
    assign wait_exit = eng_done;
`endif
    // first pending requester at or above the pointer, wrapping around
    always_comb begin
        pick = '0;
        pick_idx = '0;
        hit = 1'b0;
        idx = 0;
        j = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            j = PW'(idx);
            if (!hit && Req[j]) begin
                hit = 1'b1;
                pick[j] = 1'b1;
                pick_idx = j;
            end
        end
    end
    // next state and Moore-decoded engine handshake
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = hit ? START : IDLE;
            START:   state_n = Eng_Qi ? START : WAIT;
            WAIT:    state_n = wait_exit ? ACK : WAIT;
            ACK:     state_n = Eng_Qi ? IDLE : ACK;
            default: state_n = IDLE;
        endcase
        Eng_Start = state == START;
        Eng_Ack = state == ACK;
        Busy = state != IDLE;
    end
    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else state <= state_n;
    end
    // grant/pointer bookkeeping, result capture and the one-cycle Done pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Gnt <= '0;
            gidx <= '0;
            ptr <= '0;
            Done <= '0;
            Found <= 1'b0;
            Result <= 8'd0;
`ifdef DIV7_ARB_TIMEOUT_EN
            wd <= 8'd0;
            Timeout <= 1'b0;
`endif
        end else begin
            Done <= '0;
`ifdef DIV7_ARB_TIMEOUT_EN
            Timeout <= 1'b0;
            if (state == START) wd <= 8'd0;
            if (state == WAIT) wd <= wd + 8'd1;
            if (state == WAIT && wait_exit) Timeout <= !eng_done;
`endif
            if (state == IDLE && hit) begin
                Gnt <= pick;
                gidx <= pick_idx;
            end
            if (state == WAIT && wait_exit) begin
                Found <= Eng_Qdf;
                Result <= Eng_Qdf ? Eng_Max : (eng_done ? 8'd0 : 8'hFF);
                Done <= Gnt;
            end
            if (state == ACK && Eng_Qi) begin
                Gnt <= '0;
                ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div7_engine_arbiter.sv
// tb_div7_engine_arbiter: directed vector table plus hand sequences for stalls and async reset
module tb_div7_engine_arbiter;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic [3:0] Req = '0;
    logic [3:0] Gnt, Done;
    logic Found, Busy, Eng_Start, Eng_Ack;
    logic [7:0] Result;
    logic Eng_Qi = 1'b1;
    logic Eng_Qdf = 1'b0;
    logic Eng_Qdnf = 1'b0;
    logic [7:0] Eng_Max = '0;
`ifdef DIV7_ARB_TIMEOUT_EN
    logic Timeout;
`endif
    int n = 0;
    int errs = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] req_mid;
        logic       df;
        logic       dnf;
        logic [7:0] mx;
        logic [3:0] gnt;
        logic       fnd;
        logic [7:0] res;
    } vec_t;
    vec_t v [12];

    div7_engine_arbiter #(.NREQ(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Gnt(Gnt), .Done(Done),
        .Found(Found), .Result(Result), .Eng_Start(Eng_Start), .Eng_Ack(Eng_Ack),
        .Eng_Qi(Eng_Qi), .Eng_Qdf(Eng_Qdf), .Eng_Qdnf(Eng_Qdnf), .Eng_Max(Eng_Max),
`ifdef DIV7_ARB_TIMEOUT_EN
        .Timeout(Timeout),
`endif
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " gnt"}, Gnt, 0);
        chk({nm, " done"}, Done, 0);
        chk({nm, " busy"}, Busy, 0);
        chk({nm, " start"}, Eng_Start, 0);
        chk({nm, " ack"}, Eng_Ack, 0);
    endtask

    // one full service; entered and left on a falling edge with the DUT in IDLE
    task automatic serve(input vec_t t, input int k);
        string s;
        s = $sformatf("v%0d", k);
        Req = t.req;
        @(negedge Clk);
        chk({s, " gnt"}, Gnt, t.gnt);
        chk({s, " start"}, Eng_Start, 1);
        chk({s, " busy"}, Busy, 1);
        Eng_Qi = 1'b0;
        Req = t.req_mid;
        @(negedge Clk);
        chk({s, " start_low"}, Eng_Start, 0);
        chk({s, " gnt_wait"}, Gnt, t.gnt);
        chk({s, " done_wait"}, Done, 0);
        Eng_Qdf = t.df;
        Eng_Qdnf = t.dnf;
        Eng_Max = t.mx;
        @(negedge Clk);
        chk({s, " done"}, Done, t.gnt);
        chk({s, " found"}, Found, t.fnd);
        chk({s, " result"}, Result, t.res);
        chk({s, " ack"}, Eng_Ack, 1);
        Eng_Qdf = 1'b0;
        Eng_Qdnf = 1'b0;
        @(negedge Clk);
        chk({s, " done_once"}, Done, 0);
        chk({s, " ack2"}, Eng_Ack, 1);
        chk({s, " gnt_ack"}, Gnt, t.gnt);
        Eng_Qi = 1'b1;
        @(negedge Clk);
        chk({s, " gnt_rel"}, Gnt, 0);
        chk({s, " idle"}, Busy, 0);
        chk({s, " found_hold"}, Found, t.fnd);
        chk({s, " result_hold"}, Result, t.res);
    endtask

    initial begin
        v[0]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 8'd224, 4'b0001, 1'b1, 8'd224};
        v[1]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 8'd0,   4'b0100, 1'b0, 8'd0};
        v[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'd7,   4'b1000, 1'b1, 8'd7};
        v[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'd14,  4'b0001, 1'b1, 8'd14};
        v[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 8'd99,  4'b0010, 1'b0, 8'd0};
        v[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'd21,  4'b0100, 1'b1, 8'd21};
        v[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 8'd70,  4'b1000, 1'b1, 8'd70};
        v[7]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'd252, 4'b0001, 1'b1, 8'd252};
        v[8]  = '{4'b0010, 4'b0010, 1'b1, 1'b0, 8'd28,  4'b0010, 1'b1, 8'd28};
        v[9]  = '{4'b0011, 4'b0010, 1'b1, 1'b0, 8'd35,  4'b0001, 1'b1, 8'd35};
        v[10] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 8'd42,  4'b0010, 1'b1, 8'd42};
        v[11] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 8'd49,  4'b0010, 1'b0, 8'd0};
        @(negedge Clk);
        chk_idle_outputs("reset");
        chk("reset found", Found, 0);
        chk("reset result", Result, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("no_req");
        for (int k = 0; k < 12; k++) serve(v[k], k);
        Req = 4'b0000;
        // engine slow to leave Qi, slow to finish and slow to return to Qi
        @(negedge Clk);
        chk_idle_outputs("gap");
        Req = 4'b1000;
        @(negedge Clk);
        chk("slow gnt", Gnt, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("slow start_hold", Eng_Start, 1);
        end
        Eng_Qi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("slow wait_done", Done, 0);
            chk("slow wait_ack", Eng_Ack, 0);
            chk("slow wait_start", Eng_Start, 0);
            chk("slow wait_gnt", Gnt, 4'b1000);
        end
        Eng_Qdnf = 1'b1;
        Eng_Max = 8'd63;
        @(negedge Clk);
        chk("slow done", Done, 4'b1000);
        chk("slow found", Found, 0);
        chk("slow result", Result, 0);
        Eng_Qdnf = 1'b0;
        Req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("slow ack_hold", Eng_Ack, 1);
            chk("slow ack_done", Done, 0);
            chk("slow ack_gnt", Gnt, 4'b1000);
        end
        Eng_Qi = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("slow end");
        // move the pointer off zero, then reset in the middle of a WAIT
        serve('{4'b0100, 4'b0000, 1'b1, 1'b0, 8'd77, 4'b0100, 1'b1, 8'd77}, 100);
        Req = 4'b0010;
        @(negedge Clk);
        chk("rst gnt", Gnt, 4'b0010);
        Eng_Qi = 1'b0;
        @(negedge Clk);
        chk("rst in_wait", Eng_Start, 0);
        #2 Reset_n = 1'b0;
        Eng_Qi = 1'b1;
        Req = 4'b1111;
        #1;
        chk_idle_outputs("rst async");
        chk("rst found", Found, 0);
        chk("rst result", Result, 0);
        @(negedge Clk);
        chk("rst no_done", Done, 0);
        Reset_n = 1'b1;
        serve('{4'b1111, 4'b0000, 1'b1, 1'b0, 8'd133, 4'b0001, 1'b1, 8'd133}, 101);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
